// File: rtl/ual_sequencer_if.sv
// ============================================================================
//  Module      : ual_sequencer_if
//  Description : Switch/button inputs, ALU result and registered ALU/display
//                outputs of the UAL operand/opcode sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ual_sequencer_if #(
    parameter int M = 4
) ();
    logic [M:0]   sw;
    logic         btn_next;
    logic         btn_clear;
    logic [M-1:0] Q;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic [M:0]   ALUControl;
    logic [M-1:0] result;
    logic         result_valid;
    logic         op_err;
    logic [2:0]   state;
    logic [7:0]   op_count;

    // Board / ALU environment side
    modport master (
        output sw, btn_next, btn_clear, Q,
        input  A, B, ALUControl, result, result_valid, op_err, state, op_count
    );

    // Sequencer side
    modport slave (
        input  sw, btn_next, btn_clear, Q,
        output A, B, ALUControl, result, result_valid, op_err, state, op_count
    );
endinterface

`default_nettype wire

// File: rtl/ual_sequencer.sv
// ============================================================================
//  Module      : ual_sequencer
//  Description : Steps through operand A, operand B and opcode entry with a
//                single "next" button, then captures the ALU result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ual_sequencer #(
    parameter int M = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ual_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [M:0] c_op_max = (M+1)'(9);
    localparam logic [M:0] c_op_div = (M+1)'(3);
    localparam logic [M:0] c_op_mod = (M+1)'(4);

    state_t       state_q, state_d;
    logic [M-1:0] a_q, a_d;
    logic [M-1:0] b_q, b_d;
    logic [M:0]   op_q, op_d;
    logic [M-1:0] res_q, res_d;
    logic         rv_q, rv_d;
    logic         err_q, err_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         prev_q;

    logic         w_nxt;
    logic         w_op_bad;

    // prev resets high so a button held through reset is not seen as a press
    assign w_nxt    = bus.btn_next & ~prev_q;
    assign w_op_bad = (bus.sw > c_op_max) ||
                      (((bus.sw == c_op_div) || (bus.sw == c_op_mod)) && (b_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            prev_q  <= bus.btn_next;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        rv_d    = rv_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (bus.btn_clear) begin
            // Abort wins over a same-cycle press; the op counter survives
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            rv_d    = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (w_nxt) begin
                        a_d     = bus.sw[M-1:0];
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (w_nxt) begin
                        b_d     = bus.sw[M-1:0];
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (w_nxt) begin
                        if (w_op_bad) begin
                            err_d = 1'b1;
                        end else begin
                            op_d    = bus.sw;
                            err_d   = 1'b0;
                            state_d = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for a full cycle here
                    res_d   = bus.Q;
                    rv_d    = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (w_nxt) begin
                        rv_d    = 1'b0;
                        state_d = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.ALUControl   = op_q;
    assign bus.result       = res_q;
    assign bus.result_valid = rv_q;
    assign bus.op_err       = err_q;
    assign bus.state        = state_q;
    assign bus.op_count     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ual_sequencer.sv
// ============================================================================
//  Module      : tb_ual_sequencer
//  Description : Self-checking bench for ual_sequencer with a behavioural ALU
//                and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ual_sequencer;

    localparam int M = 4;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    logic [7:0]   exp_cnt;
    logic [M-1:0] sb_q[$];
    logic         rv_prev;

    ual_sequencer_if #(.M(M)) bus ();

    ual_sequencer #(.M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [M-1:0] alu(input logic [M-1:0] a, input logic [M-1:0] b,
                                         input logic [M:0] op);
        logic [M-1:0] r;
        r = '0;
        case (op)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a * b;
            5'd3: r = (b != 0) ? a / b : '0;
            5'd4: r = (b != 0) ? a % b : '0;
            5'd5: r = a & b;
            5'd6: r = a | b;
            5'd7: r = a ^ b;
            5'd8: r = a << b;
            5'd9: r = a >> b;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb bus.Q = alu(bus.A, bus.B, bus.ALUControl);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: pop an expected result on every rising result_valid
    initial rv_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1 && rv_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'(bus.result), 32'hFFFF_FFFF);
            end else begin
                chk("sb_result", 32'(bus.result), 32'(sb_q.pop_front()));
                chk("sb_count", 32'(bus.op_count), 32'(exp_cnt));
            end
        end
        rv_prev = bus.result_valid;
    end

    task automatic press(input logic [M:0] v);
        @(negedge clk);
        bus.sw       = v;
        bus.btn_next = 1'b1;
        @(negedge clk);
        bus.btn_next = 1'b0;
    endtask

    task automatic do_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M:0] op);
        press({1'b0, a});
        press({1'b0, b});
        sb_q.push_back(alu(a, b, op));
        exp_cnt = exp_cnt + 8'd1;
        press(op);
        @(negedge clk);
        press('0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M-1:0] ra, rb;
        logic [M:0]   rop;
        int           guard;

        n_total       = 0;
        n_bad         = 0;
        exp_cnt       = 8'd0;
        rst           = 1'b1;
        bus.btn_next  = 1'b1;
        bus.btn_clear = 1'b0;
        bus.sw        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_A", 32'(bus.A), 0);
        chk("rst_B", 32'(bus.B), 0);
        chk("rst_op", 32'(bus.ALUControl), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_rv", 32'(bus.result_valid), 0);
        chk("rst_err", 32'(bus.op_err), 0);
        chk("rst_cnt", 32'(bus.op_count), 0);
        repeat (5) @(negedge clk);
        chk("held_state", 32'(bus.state), 0);
        bus.btn_next = 1'b0;

        // Add 5 + 3
        press(5'd5);
        chk("add_A", 32'(bus.A), 5);
        chk("add_stB", 32'(bus.state), 1);
        press(5'd3);
        chk("add_B", 32'(bus.B), 3);
        chk("add_stOP", 32'(bus.state), 2);
        sb_q.push_back(4'd8);
        exp_cnt = exp_cnt + 8'd1;
        press(5'd0);
        chk("add_stEXEC", 32'(bus.state), 3);
        chk("add_rv_pre", 32'(bus.result_valid), 0);
        @(negedge clk);
        chk("add_stSHOW", 32'(bus.state), 4);
        chk("add_result", 32'(bus.result), 8);
        chk("add_rv", 32'(bus.result_valid), 1);
        chk("add_cnt", 32'(bus.op_count), 1);
        press(5'd0);
        chk("add_back", 32'(bus.state), 0);
        chk("add_rv_clr", 32'(bus.result_valid), 0);
        chk("add_keep", 32'(bus.result), 8);

        // Division / modulo by zero, then AND accepted
        press(5'd9);
        press(5'd0);
        press(5'd3);
        chk("div0_err", 32'(bus.op_err), 1);
        chk("div0_st", 32'(bus.state), 2);
        press(5'd4);
        chk("mod0_err", 32'(bus.op_err), 1);
        chk("mod0_st", 32'(bus.state), 2);
        sb_q.push_back(4'd0);
        exp_cnt = exp_cnt + 8'd1;
        press(5'd5);
        chk("and_err", 32'(bus.op_err), 0);
        chk("and_op", 32'(bus.ALUControl), 5);
        @(negedge clk);
        chk("and_result", 32'(bus.result), 0);
        press(5'd0);

        // Illegal opcode keeps previous ALUControl
        press(5'd7);
        press(5'd2);
        press(5'd12);
        chk("ill_err", 32'(bus.op_err), 1);
        chk("ill_st", 32'(bus.state), 2);
        chk("ill_op", 32'(bus.ALUControl), 5);
        sb_q.push_back(4'd5);
        exp_cnt = exp_cnt + 8'd1;
        press(5'd1);
        chk("sub_err", 32'(bus.op_err), 0);
        @(negedge clk);
        chk("sub_result", 32'(bus.result), 5);
        press(5'd0);

        // Clear in S_OP together with a next edge
        press(5'd6);
        press(5'd1);
        press(5'd15);
        chk("clr_pre_err", 32'(bus.op_err), 1);
        @(negedge clk);
        bus.sw        = 5'd2;
        bus.btn_next  = 1'b1;
        bus.btn_clear = 1'b1;
        @(negedge clk);
        bus.btn_next  = 1'b0;
        bus.btn_clear = 1'b0;
        chk("clr_state", 32'(bus.state), 0);
        chk("clr_A", 32'(bus.A), 0);
        chk("clr_B", 32'(bus.B), 0);
        chk("clr_op", 32'(bus.ALUControl), 0);
        chk("clr_result", 32'(bus.result), 0);
        chk("clr_err", 32'(bus.op_err), 0);
        chk("clr_cnt", 32'(bus.op_count), 32'(exp_cnt));

        // Switch changes without a press have no effect
        bus.sw = 5'd11;
        repeat (3) @(negedge clk);
        chk("sw_idle_st", 32'(bus.state), 0);
        chk("sw_idle_A", 32'(bus.A), 0);

        // A press held for several cycles advances once
        bus.sw       = 5'd10;
        bus.btn_next = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_next = 1'b0;
        chk("hold_st", 32'(bus.state), 1);
        chk("hold_A", 32'(bus.A), 10);
        press(5'd2);
        sb_q.push_back(4'd12);
        exp_cnt = exp_cnt + 8'd1;
        press(5'd0);
        @(negedge clk);
        press(5'd0);

        // Random legal operations until the counter wraps
        guard = 0;
        while (exp_cnt != 8'd0 && guard < 300) begin
            ra  = M'($urandom_range(0, 15));
            rb  = M'($urandom_range(0, 15));
            rop = (M+1)'($urandom_range(0, 9));
            if ((rop == 5'd3 || rop == 5'd4) && rb == '0) rb = 4'd1;
            do_op(ra, rb, rop);
            guard++;
        end
        chk("wrap_cnt", 32'(bus.op_count), 0);

        // Reset during S_EXEC: no capture, counter cleared
        press(5'd3);
        press(5'd4);
        press(5'd2);
        chk("mid_st", 32'(bus.state), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        chk("mid_state", 32'(bus.state), 0);
        chk("mid_result", 32'(bus.result), 0);
        chk("mid_rv", 32'(bus.result_valid), 0);
        chk("mid_cnt", 32'(bus.op_count), 0);
        repeat (3) @(negedge clk);
        chk("mid_rv_late", 32'(bus.result_valid), 0);
        chk("sb_drain", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
